ssb_phasing_combiner: RTL
=========================

Name: ssb_phasing_combiner

Overview:
- Back end of the phasing-method SSB transmit path.
- Consumes the audio sample (I) and its Hilbert-transformed quadrature (Q) as one sample stream, together with carrier cos/sin words from the NCO.
- Delays I to match the Hilbert filter group delay and forms USB = I·cos − Q·sin or LSB = I·cos + Q·sin.
- Uses one shared multiplier under a small FSM and emits one saturated 16-bit sample per accepted input.

Parameters:
- I_DELAY, 15, I-path delay in samples; matches the 31-tap Hilbert group delay. Legal range ≥1.
- FRAC, 15, right-shift applied to the product sum (Q1.15 operands).

Ports:
- clk  in  1  system clock, 4.4 MHz.
- rst  in  1  reset; asynchronous, active-high.
- in_valid  in  1  single-cycle strobe: i_in, q_in, cos_in, sin_in and sideband_sel are valid.
- i_in  in  16  signed in-phase audio sample.
- q_in  in  16  signed Hilbert output for the same sample index.
- cos_in  in  16  signed carrier cosine, Q1.15.
- sin_in  in  16  signed carrier sine, Q1.15.
- sideband_sel  in  1  0 = USB, 1 = LSB; sampled with in_valid.
- dout  out  16  signed SSB sample.
- out_valid  out  1  one-cycle strobe: dout is new.
- busy  out  1  high in MUL_I, MUL_Q and OUT.
- overrun  out  1  sticky; an in_valid arrived while busy.

Behaviour:

Reset (async, immediate):
- dout=0, out_valid=0, busy=0, overrun=0, state=IDLE, write pointer=0, all delay-buffer entries=0, accumulator=0.
- Reset mid-operation aborts the sample: no out_valid is produced for it.

Delay line:
- Circular buffer of I_DELAY × 16 bits.
- On an accepted in_valid, read i_d=buf[wptr], then write buf[wptr]=i_in in the same edge.
- wptr increments and wraps I_DELAY−1 → 0 (non-power-of-two depth supported).
- Result: i_d for accepted sample k is i_in of sample k−I_DELAY.
- i_d is 0 for the first I_DELAY samples after reset.

FSM (IDLE → MUL_I → MUL_Q → OUT → IDLE):
- IDLE: on in_valid, latch i_d, q_in, cos_in, sin_in and sideband_sel; advance the pointer; go to MUL_I.
- MUL_I: acc(33b signed) = i_d·cos.
- MUL_Q: acc = acc − q·sin (USB) or acc + q·sin (LSB), full 33-bit precision, no intermediate truncation.
- OUT: dout <= sat16(acc >>> FRAC), arithmetic shift (floor), clamped to [−32768, 32767]; out_valid=1 for this one cycle; return to IDLE.

Latency and throughput:
- out_valid is high in the 3rd cycle after the edge that accepted in_valid; dout is registered and holds until the next OUT.
- Minimum in_valid spacing is 4 clocks. The nominal audio rate is ~92 clocks/sample.

Handshake and boundaries:
- in_valid is accepted only in IDLE.
- in_valid while busy (including in OUT) is dropped: buffer untouched, pointer untouched, no extra output, overrun=1 until rst.
- in_valid in the cycle after OUT (IDLE) is accepted normally.
- Only one multiplier (16×16 signed) is instantiated; it is operand-muxed by state.

Test Plan:
1. Reset defaults: assert rst asynchronously mid-cycle → dout=0, out_valid=0, busy=0, overrun=0 immediately; no out_valid in the following 10 clocks with in_valid=0.
2. Delay alignment: 20 samples, every 92 clocks; i_in=1000·k (k=1..20), q=0, cos=16384, sin=0, USB → outputs 1–15 are dout=0; output 16 is dout=500; output 20 is dout=2500; each out_valid is exactly 3 clocks after its in_valid.
3. Sideband select: ≥16 samples of i_in=16384, then q=16384, cos=16384, sin=16384 → USB dout=0; LSB dout=16384.
4. Saturation:
   - Steady i_in=−32768, cos=−32768, q=−32768, sin=32767, USB → raw 2147450880>>>15=65535 → dout=32767.
   - Steady i_in=32767, cos=−32768, q=32767, sin=32767, USB → dout=−32768.
   - First case in LSB → dout=1.
5. Overrun: in_valid at clock 0 and again at clock 2 → exactly one out_valid (clock 3); overrun=1 from clock 3 and sticky; wptr advanced once (check via subsequent delay alignment).
6. Reset mid-operation: rst asserted during MUL_Q after 10 ramp samples → no out_valid for that sample; after release the next 15 outputs use i_d=0 (buffer cleared).

Source files
------------

// File: rtl/ssb_phasing_combiner.sv
// Phasing-method SSB combiner: delays I to align with the Hilbert quadrature and
// forms I*cos -/+ Q*sin on one shared 16x16 multiplier, saturated to 16 bits.
module ssb_phasing_combiner #(
  parameter int I_DELAY = 15,
  parameter int FRAC    = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic signed [15:0] i_in,
  input  logic signed [15:0] q_in,
  input  logic signed [15:0] cos_in,
  input  logic signed [15:0] sin_in,
  input  logic               sideband_sel,
  output logic signed [15:0] dout,
  output logic               out_valid,
  output logic               busy,
  output logic               overrun
);

  // state  | meaning
  // IDLE   | waiting for in_valid; the only state that accepts a sample
  // MUL_I  | acc = i_d * cos
  // MUL_Q  | acc = acc -/+ q * sin, saturated result registered into dout
  // OUT    | out_valid high, dout holds the new sample
  typedef enum logic [1:0] {IDLE, MUL_I, MUL_Q, OUT} state_t;

  localparam int PTR_W = (I_DELAY > 1) ? $clog2(I_DELAY) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(I_DELAY - 1);

  state_t             state, state_nxt;
  logic signed [15:0] dly_buf [I_DELAY];
  logic [PTR_W-1:0]   wptr;
  logic signed [15:0] i_r, q_r, cos_r, sin_r;
  logic               sel_r;
  logic signed [32:0] acc, acc_nxt, shifted;
  logic signed [15:0] mul_a, mul_b;
  logic signed [31:0] prod;
  logic signed [32:0] prod_ext;
  logic signed [15:0] sat_val;
  logic               accept;

  assign accept = in_valid && (state == IDLE);
  assign busy   = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = MUL_I;
      MUL_I:   state_nxt = MUL_Q;
      MUL_Q:   state_nxt = OUT;
      OUT:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The single multiplier sees I/cos in MUL_I and Q/sin otherwise.
  always_comb begin
    mul_a = i_r;
    mul_b = cos_r;
    if (state == MUL_Q) begin
      mul_a = q_r;
      mul_b = sin_r;
    end
  end

  assign prod     = mul_a * mul_b;
  assign prod_ext = {prod[31], prod};

  always_comb begin
    acc_nxt = acc;
    case (state)
      MUL_I:   acc_nxt = prod_ext;
      MUL_Q:   acc_nxt = sel_r ? (acc + prod_ext) : (acc - prod_ext);
      default: acc_nxt = acc;
    endcase
  end

  // Arithmetic shift floors toward minus infinity before the clamp.
  always_comb begin
    shifted = acc_nxt >>> FRAC;
    sat_val = shifted[15:0];
    if (shifted > 33'sd32767)
      sat_val = 16'sh7fff;
    else if (shifted < -33'sd32768)
      sat_val = 16'sh8000;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      wptr      <= '0;
      for (int k = 0; k < I_DELAY; k++) dly_buf[k] <= '0;
      i_r       <= '0;
      q_r       <= '0;
      cos_r     <= '0;
      sin_r     <= '0;
      sel_r     <= 1'b0;
      acc       <= '0;
      dout      <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_nxt;
      out_valid <= 1'b0;
      if (accept) begin
        i_r           <= dly_buf[wptr];
        dly_buf[wptr] <= i_in;
        q_r           <= q_in;
        cos_r         <= cos_in;
        sin_r         <= sin_in;
        sel_r         <= sideband_sel;
        wptr          <= (wptr == PTR_LAST) ? '0 : wptr + 1'b1;
      end
      if (in_valid && (state != IDLE)) overrun <= 1'b1;
      if ((state == MUL_I) || (state == MUL_Q)) acc <= acc_nxt;
      // Register the result on entry to OUT so dout is stable while out_valid is high.
      if (state == MUL_Q) begin
        dout      <= sat_val;
        out_valid <= 1'b1;
      end
    end
  end

endmodule
